// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM ownership arbiter and its address pointer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arb_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_TIMEOUT    = 64;

    // RAM direction encoding on RAM_RW / CPU_RAM_RW
    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    typedef enum logic [2:0] {
        CPU_OWN,
        HALT_WAIT,
        LD_OWN,
        LD_RDWAIT,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/arb_addr_pointer.sv
// Loadable, auto-incrementing address pointer; wraps from all-ones to zero.
// Latency: new value visible the cycle after load/inc.
// Backpressure: none; load and inc are honoured every cycle. Load together with inc yields load_addr + 1.
// Ports: clk, rst (sync, active-high), load/load_addr, inc, ptr (current value).
module arb_addr_pointer
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    logic [ADDR_WIDTH-1:0] base;

    // The address used by an access is the loaded one when both arrive together,
    // so the next pointer is relative to that base.
    assign base = load ? load_addr : ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load || inc) begin
            ptr <= base + {{(ADDR_WIDTH-1){1'b0}}, inc};
        end
    end

endmodule

// File: rtl/ram_loader_arbiter.sv
// Arbitrates the single RAM port between the CPU and an external loader/debug port.
// Latency: request->grant >= 2 cycles; write ACK 1 cycle after strobe; read ACK/data 2 cycles after strobe.
// Backpressure: loader waits for LD_GNT, then for LD_ACK between reads; writes accepted every cycle.
// Ports: CLK/RST; LD_* loader session and access interface; CPU_* controller/MAR side;
//        HALT freezes the controller; RAM_* drive the memory block, RAM_RDATA returns read data.
module ram_loader_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LD_REQ,
    output logic                  LD_GNT,
    input  logic [ADDR_WIDTH-1:0] LD_ADDR,
    input  logic                  LD_ADDR_LOAD,
    input  logic                  LD_WR,
    input  logic                  LD_RD,
    input  logic [WIDTH-1:0]      LD_WDATA,
    output logic [WIDTH-1:0]      LD_RDATA,
    output logic                  LD_ACK,
    output logic                  LD_ERR,
    input  logic                  CPU_BOUNDARY,
    input  logic [ADDR_WIDTH-1:0] CPU_ADDR,
    input  logic                  CPU_RAM_EN,
    input  logic                  CPU_RAM_RW,
    output logic                  HALT,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic                  RAM_EN,
    output logic                  RAM_RW,
    output logic [WIDTH-1:0]      RAM_WDATA,
    output logic                  RAM_WDATA_OE,
    input  logic [WIDTH-1:0]      RAM_RDATA
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t            state;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  ld_req_q;
    logic                  retry_block;   // set by a timeout, held until LD_REQ falls
    logic                  halt_q;
    logic                  gnt_q;
    logic                  ack_q;
    logic                  err_q;
    logic [WIDTH-1:0]      rdata_q;

    logic                  in_ld_own;
    logic                  ld_wr_acc;
    logic                  ld_rd_acc;
    logic                  ptr_load;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] acc_addr;

    assign in_ld_own = (state == LD_OWN);
    // Write has priority when both strobes arrive; the read is simply dropped.
    assign ld_wr_acc = in_ld_own && LD_WR;
    assign ld_rd_acc = in_ld_own && LD_RD && !LD_WR;
    assign ptr_load  = in_ld_own && LD_ADDR_LOAD;
    assign acc_addr  = LD_ADDR_LOAD ? LD_ADDR : ptr;

    arb_addr_pointer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ptr (
        .clk       (CLK),
        .rst       (RST),
        .load      (ptr_load),
        .load_addr (LD_ADDR),
        .inc       (ld_wr_acc || ld_rd_acc),
        .ptr       (ptr)
    );

    // RAM port mux. CPU keeps the port until the grant; outside loader write
    // cycles the write-data driver stays off so the bus is never contended.
    always_comb begin
        RAM_ADDR     = ptr;
        RAM_EN       = 1'b0;
        RAM_RW       = RAM_READ;
        RAM_WDATA_OE = 1'b0;
        case (state)
            CPU_OWN, HALT_WAIT: begin
                RAM_ADDR = CPU_ADDR;
                RAM_EN   = CPU_RAM_EN;
                RAM_RW   = CPU_RAM_RW;
            end
            LD_OWN: begin
                RAM_ADDR     = acc_addr;
                RAM_EN       = ld_wr_acc || ld_rd_acc;
                RAM_RW       = ld_wr_acc ? RAM_WRITE : RAM_READ;
                RAM_WDATA_OE = ld_wr_acc;
            end
            default: ;
        endcase
    end

    assign RAM_WDATA = LD_WDATA;
    assign HALT      = halt_q;
    assign LD_GNT    = gnt_q;
    assign LD_ACK    = ack_q;
    assign LD_ERR    = err_q;
    assign LD_RDATA  = rdata_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= CPU_OWN;
            wait_cnt    <= '0;
            ld_req_q    <= 1'b0;
            retry_block <= 1'b0;
            halt_q      <= 1'b0;
            gnt_q       <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ld_req_q <= LD_REQ;
            ack_q    <= 1'b0;
            // A fresh request clears a stale error; a timeout can never coincide
            // with a rising edge because LD_REQ was already high.
            if (LD_REQ && !ld_req_q) begin
                err_q <= 1'b0;
            end
            if (!LD_REQ) begin
                retry_block <= 1'b0;
            end

            case (state)
                CPU_OWN: begin
                    if (LD_REQ && !retry_block) begin
                        state    <= HALT_WAIT;
                        wait_cnt <= '0;
                    end
                end
                HALT_WAIT: begin
                    if (!LD_REQ) begin
                        state <= CPU_OWN;
                    end else if (CPU_BOUNDARY) begin
                        state  <= LD_OWN;
                        halt_q <= 1'b1;
                        gnt_q  <= 1'b1;
                    end else if (wait_cnt == CNT_LAST) begin
                        state       <= CPU_OWN;
                        err_q       <= 1'b1;
                        retry_block <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                LD_OWN: begin
                    if (ld_wr_acc) begin
                        ack_q <= 1'b1;
                        if (!LD_REQ) begin
                            state <= RELEASE;
                            gnt_q <= 1'b0;
                        end
                    end else if (ld_rd_acc) begin
                        state <= LD_RDWAIT;
                    end else if (!LD_REQ) begin
                        state <= RELEASE;
                        gnt_q <= 1'b0;
                    end
                end
                LD_RDWAIT: begin
                    // Synchronous RAM data is on RAM_RDATA now; strobes are ignored.
                    rdata_q <= RAM_RDATA;
                    ack_q   <= 1'b1;
                    if (!LD_REQ) begin
                        state <= RELEASE;
                        gnt_q <= 1'b0;
                    end else begin
                        state <= LD_OWN;
                    end
                end
                RELEASE: begin
                    state  <= CPU_OWN;
                    halt_q <= 1'b0;
                end
                default: begin
                    state  <= CPU_OWN;
                    halt_q <= 1'b0;
                    gnt_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader_arbiter.sv
// Directed bench for ram_loader_arbiter with a synchronous-read RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_loader_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req, ld_gnt, ld_addr_load, ld_wr, ld_rd, ld_ack, ld_err;
    logic [15:0] ld_addr, ld_wdata, ld_rdata;
    logic        cpu_boundary, cpu_ram_en, cpu_ram_rw, halt;
    logic [15:0] cpu_addr;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_en, ram_rw, ram_wdata_oe;

    logic [15:0] mem [0:65535];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    // Memory block: write on enable+RW, registered read data one cycle later.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_rw) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    ram_loader_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(8)) dut (
        .CLK(clk), .RST(rst),
        .LD_REQ(ld_req), .LD_GNT(ld_gnt), .LD_ADDR(ld_addr), .LD_ADDR_LOAD(ld_addr_load),
        .LD_WR(ld_wr), .LD_RD(ld_rd), .LD_WDATA(ld_wdata), .LD_RDATA(ld_rdata),
        .LD_ACK(ld_ack), .LD_ERR(ld_err),
        .CPU_BOUNDARY(cpu_boundary), .CPU_ADDR(cpu_addr), .CPU_RAM_EN(cpu_ram_en),
        .CPU_RAM_RW(cpu_ram_rw), .HALT(halt),
        .RAM_ADDR(ram_addr), .RAM_EN(ram_en), .RAM_RW(ram_rw), .RAM_WDATA(ram_wdata),
        .RAM_WDATA_OE(ram_wdata_oe), .RAM_RDATA(ram_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ld_req = 0; ld_addr = 0; ld_addr_load = 0; ld_wr = 0; ld_rd = 0; ld_wdata = 0;
        cpu_boundary = 0; cpu_addr = 0; cpu_ram_en = 0; cpu_ram_rw = 0;
        tick; tick;
        n_checks++; if (halt !== 1'b0)     begin n_fail++; $display("FAIL rst_halt: got %b want 0", halt); end
        n_checks++; if (ld_gnt !== 1'b0)   begin n_fail++; $display("FAIL rst_gnt: got %b want 0", ld_gnt); end
        n_checks++; if (ld_ack !== 1'b0)   begin n_fail++; $display("FAIL rst_ack: got %b want 0", ld_ack); end
        n_checks++; if (ld_err !== 1'b0)   begin n_fail++; $display("FAIL rst_err: got %b want 0", ld_err); end
        n_checks++; if (ld_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0000", ld_rdata); end
        n_checks++; if (ram_wdata_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b want 0", ram_wdata_oe); end
        rst = 1'b0;
        cpu_addr = 16'h0012; cpu_ram_en = 1'b1; cpu_ram_rw = 1'b1;
        #1;
        n_checks++; if (ram_addr !== 16'h0012) begin n_fail++; $display("FAIL idle_addr: got %h want 0012", ram_addr); end
        n_checks++; if (ram_en !== 1'b1)   begin n_fail++; $display("FAIL idle_en: got %b want 1", ram_en); end
        n_checks++; if (ram_rw !== 1'b1)   begin n_fail++; $display("FAIL idle_rw: got %b want 1", ram_rw); end
        n_checks++; if (halt !== 1'b0)     begin n_fail++; $display("FAIL idle_halt: got %b want 0", halt); end
        tick;
    endtask

    task automatic test_grant;
        cpu_ram_en = 1'b0; cpu_ram_rw = 1'b0; cpu_boundary = 1'b0;
        ld_req = 1'b1;                                   // cycle 0
        for (int c = 0; c < 6; c++) begin
            if (c == 5) cpu_boundary = 1'b1;
            #1;
            n_checks++; if (halt !== 1'b0 || ld_gnt !== 1'b0 || ram_en !== 1'b0) begin
                n_fail++; $display("FAIL grant_wait c%0d: halt=%b gnt=%b en=%b want 0/0/0", c, halt, ld_gnt, ram_en);
            end
            tick;
        end
        cpu_boundary = 1'b0;                             // cycle 6
        #1;
        n_checks++; if (halt !== 1'b1)   begin n_fail++; $display("FAIL grant_halt: got %b want 1", halt); end
        n_checks++; if (ld_gnt !== 1'b1) begin n_fail++; $display("FAIL grant_gnt: got %b want 1", ld_gnt); end
        n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL grant_idle_en: got %b want 0", ram_en); end
    endtask

    task automatic test_back_to_back;
        ld_addr = 16'hFFFE; ld_addr_load = 1'b1; ld_wr = 1'b1; ld_wdata = 16'hAAAA;
        #1;
        n_checks++; if (ram_addr !== 16'hFFFE || ram_en !== 1'b1 || ram_rw !== 1'b1 || ram_wdata_oe !== 1'b1) begin
            n_fail++; $display("FAIL wr0_bus: addr=%h en=%b rw=%b oe=%b want FFFE/1/1/1", ram_addr, ram_en, ram_rw, ram_wdata_oe);
        end
        n_checks++; if (ld_ack !== 1'b0) begin n_fail++; $display("FAIL wr0_ack: got %b want 0", ld_ack); end
        tick;
        ld_addr_load = 1'b0; ld_wdata = 16'hBBBB;
        #1;
        n_checks++; if (ram_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wr1_addr: got %h want FFFF", ram_addr); end
        n_checks++; if (ld_ack !== 1'b1) begin n_fail++; $display("FAIL wr0_ack_pulse: got %b want 1", ld_ack); end
        tick;
        ld_wdata = 16'hCCCC;
        #1;
        n_checks++; if (ram_addr !== 16'h0000) begin n_fail++; $display("FAIL wr2_addr_wrap: got %h want 0000", ram_addr); end
        n_checks++; if (ld_ack !== 1'b1) begin n_fail++; $display("FAIL wr1_ack_pulse: got %b want 1", ld_ack); end
        tick;
        ld_wr = 1'b0;
        #1;
        n_checks++; if (ld_ack !== 1'b1) begin n_fail++; $display("FAIL wr2_ack_pulse: got %b want 1", ld_ack); end
        n_checks++; if (ram_en !== 1'b0 || ram_wdata_oe !== 1'b0) begin
            n_fail++; $display("FAIL wr_idle_bus: en=%b oe=%b want 0/0", ram_en, ram_wdata_oe);
        end
        n_checks++; if (ram_addr !== 16'h0001) begin n_fail++; $display("FAIL wr_ptr_end: got %h want 0001", ram_addr); end
        tick;
        n_checks++; if (ld_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_extra: got %b want 0", ld_ack); end
        n_checks++; if (mem[16'hFFFE] !== 16'hAAAA || mem[16'hFFFF] !== 16'hBBBB || mem[16'h0000] !== 16'hCCCC) begin
            n_fail++; $display("FAIL wr_mem: got %h %h %h want AAAA BBBB CCCC", mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000]);
        end
    endtask

    task automatic test_read;
        ld_addr = 16'h0100; ld_addr_load = 1'b1;
        tick;
        ld_addr_load = 1'b0;
        #1;
        n_checks++; if (ram_addr !== 16'h0100 || ram_en !== 1'b0) begin
            n_fail++; $display("FAIL rd_load: addr=%h en=%b want 0100/0", ram_addr, ram_en);
        end
        ld_rd = 1'b1;                                    // strobe cycle
        #1;
        n_checks++; if (ram_en !== 1'b1 || ram_rw !== 1'b0 || ram_wdata_oe !== 1'b0) begin
            n_fail++; $display("FAIL rd_bus: en=%b rw=%b oe=%b want 1/0/0", ram_en, ram_rw, ram_wdata_oe);
        end
        tick;
        ld_rd = 1'b0;
        #1;
        n_checks++; if (ld_ack !== 1'b0 || ram_en !== 1'b0) begin
            n_fail++; $display("FAIL rd_wait: ack=%b en=%b want 0/0", ld_ack, ram_en);
        end
        tick;
        n_checks++; if (ld_ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack: got %b want 1", ld_ack); end
        n_checks++; if (ld_rdata !== 16'h1234) begin n_fail++; $display("FAIL rd_data: got %h want 1234", ld_rdata); end
        n_checks++; if (ram_addr !== 16'h0101) begin n_fail++; $display("FAIL rd_ptr: got %h want 0101", ram_addr); end
        // Both strobes: the write is taken, no read follows.
        ld_wr = 1'b1; ld_rd = 1'b1; ld_wdata = 16'h7777;
        #1;
        n_checks++; if (ram_rw !== 1'b1 || ram_wdata_oe !== 1'b1) begin
            n_fail++; $display("FAIL both_rw: rw=%b oe=%b want 1/1", ram_rw, ram_wdata_oe);
        end
        tick;
        ld_wr = 1'b0; ld_rd = 1'b0;
        #1;
        n_checks++; if (ld_ack !== 1'b1 || ram_addr !== 16'h0102) begin
            n_fail++; $display("FAIL both_ack: ack=%b addr=%h want 1/0102", ld_ack, ram_addr);
        end
        n_checks++; if (mem[16'h0101] !== 16'h7777) begin n_fail++; $display("FAIL both_mem: got %h want 7777", mem[16'h0101]); end
        tick;
        n_checks++; if (ld_ack !== 1'b0) begin n_fail++; $display("FAIL both_no_rdack: got %b want 0", ld_ack); end
    endtask

    task automatic test_release_mid_read;
        cpu_addr = 16'h0034; cpu_ram_en = 1'b1;
        ld_addr = 16'h0200; ld_addr_load = 1'b1; ld_rd = 1'b1; ld_req = 1'b0;
        #1;
        n_checks++; if (ram_addr !== 16'h0200 || ram_en !== 1'b1 || ram_rw !== 1'b0) begin
            n_fail++; $display("FAIL rel_rd_bus: addr=%h en=%b rw=%b want 0200/1/0", ram_addr, ram_en, ram_rw);
        end
        tick;
        ld_addr_load = 1'b0; ld_rd = 1'b0;
        #1;
        n_checks++; if (ram_en !== 1'b0 || halt !== 1'b1 || ld_ack !== 1'b0) begin
            n_fail++; $display("FAIL rel_rdwait: en=%b halt=%b ack=%b want 0/1/0", ram_en, halt, ld_ack);
        end
        tick;
        n_checks++; if (ld_ack !== 1'b1 || ld_rdata !== 16'h5A5A) begin
            n_fail++; $display("FAIL rel_ack: ack=%b data=%h want 1/5A5A", ld_ack, ld_rdata);
        end
        n_checks++; if (ram_en !== 1'b0 || ram_wdata_oe !== 1'b0 || halt !== 1'b1 || ld_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rel_turnaround: en=%b oe=%b halt=%b gnt=%b want 0/0/1/0", ram_en, ram_wdata_oe, halt, ld_gnt);
        end
        tick;
        n_checks++; if (halt !== 1'b0 || ram_en !== 1'b1 || ram_addr !== 16'h0034 || ld_ack !== 1'b0) begin
            n_fail++; $display("FAIL rel_cpu_back: halt=%b en=%b addr=%h ack=%b want 0/1/0034/0", halt, ram_en, ram_addr, ld_ack);
        end
    endtask

    task automatic test_timeout;
        cpu_ram_en = 1'b0; cpu_boundary = 1'b0;
        ld_req = 1'b1;                                   // cycle 0
        for (int c = 0; c < 9; c++) begin
            #1;
            n_checks++; if (ld_err !== 1'b0 || halt !== 1'b0) begin
                n_fail++; $display("FAIL to_wait c%0d: err=%b halt=%b want 0/0", c, ld_err, halt);
            end
            tick;
        end
        n_checks++; if (ld_err !== 1'b1 || halt !== 1'b0) begin
            n_fail++; $display("FAIL to_err: err=%b halt=%b want 1/0", ld_err, halt);
        end
        // Still requesting: no retry until LD_REQ has fallen.
        cpu_boundary = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            n_checks++; if (halt !== 1'b0 || ld_err !== 1'b1) begin
                n_fail++; $display("FAIL to_blocked c%0d: halt=%b err=%b want 0/1", c, halt, ld_err);
            end
        end
        ld_req = 1'b0;
        tick;
        n_checks++; if (ld_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", ld_err); end
        ld_req = 1'b1;
        tick;
        n_checks++; if (ld_err !== 1'b0 || halt !== 1'b0) begin
            n_fail++; $display("FAIL retry_clr: err=%b halt=%b want 0/0", ld_err, halt);
        end
        tick;
        n_checks++; if (halt !== 1'b1 || ld_gnt !== 1'b1) begin
            n_fail++; $display("FAIL retry_grant2: halt=%b gnt=%b want 1/1", halt, ld_gnt);
        end
    endtask

    task automatic test_reset_mid_session;
        rst = 1'b1; ld_wr = 1'b1; ld_wdata = 16'hDEAD;
        tick;
        n_checks++; if (halt !== 1'b0 || ld_gnt !== 1'b0 || ld_ack !== 1'b0) begin
            n_fail++; $display("FAIL mrst_ctl: halt=%b gnt=%b ack=%b want 0/0/0", halt, ld_gnt, ld_ack);
        end
        n_checks++; if (ld_err !== 1'b0 || ld_rdata !== 16'h0 || ram_wdata_oe !== 1'b0) begin
            n_fail++; $display("FAIL mrst_data: err=%b rdata=%h oe=%b want 0/0000/0", ld_err, ld_rdata, ram_wdata_oe);
        end
        ld_wr = 1'b0; ld_req = 1'b0;
        tick;
        rst = 1'b0; ld_req = 1'b1; cpu_boundary = 1'b1;
        tick; tick;
        n_checks++; if (halt !== 1'b1 || ram_addr !== 16'h0000) begin
            n_fail++; $display("FAIL mrst_ptr: halt=%b addr=%h want 1/0000", halt, ram_addr);
        end
        ld_req = 1'b0; cpu_boundary = 1'b0;
        tick; tick;
    endtask

    initial begin
        mem[16'h0100] = 16'h1234;
        mem[16'h0101] = 16'h0000;
        mem[16'h0200] = 16'h5A5A;
        test_reset;
        test_grant;
        test_back_to_back;
        test_read;
        test_release_mid_read;
        test_timeout;
        test_reset_mid_session;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_loader_arbiter.md
Name: ram_loader_arbiter

Overview:
- Arbitrates the single 16-bit RAM port between the CPU (controller/MAR path) and an external loader/debug port.
- On loader request, waits for an instruction boundary, freezes the CPU via HALT, and serves loader reads/writes with an auto-incrementing address pointer.
- Returns RAM to the CPU after a turnaround cycle.
- Sits between the controller/MAR and the memory block, replacing the ad-hoc OR of external RW/RAM_EN with CPU control.

Parameters:
- WIDTH, 16, data word width.
- ADDR_WIDTH, 16, RAM address width.
- TIMEOUT, 64, max cycles in HALT_WAIT before abandoning the request. Must be ≥2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- LD_REQ  in  1  loader requests RAM ownership; level, held for the whole session.
- LD_GNT  out  1  loader owns RAM (state LD_OWN).
- LD_ADDR  in  ADDR_WIDTH  start address for the pointer.
- LD_ADDR_LOAD  in  1  load pointer from LD_ADDR.
- LD_WR  in  1  write strobe, one word.
- LD_RD  in  1  read strobe, one word.
- LD_WDATA  in  WIDTH  write data.
- LD_RDATA  out  WIDTH  read data, valid when LD_ACK is high after a read.
- LD_ACK  out  1  one-cycle completion pulse per access.
- LD_ERR  out  1  sticky: set on HALT_WAIT timeout; cleared by RST or a new LD_REQ rising edge.
- CPU_BOUNDARY  in  1  controller is at fetch T0 (instruction boundary).
- CPU_ADDR  in  ADDR_WIDTH  MAR output.
- CPU_RAM_EN  in  1  CPU RAM enable.
- CPU_RAM_RW  in  1  CPU RAM direction, 1 = write.
- HALT  out  1  freezes the controller clock and MAR.
- RAM_ADDR  out  ADDR_WIDTH  to memory.
- RAM_EN  out  1  to memory.
- RAM_RW  out  1  to memory, 1 = write.
- RAM_WDATA  out  WIDTH  loader write data onto bus.
- RAM_WDATA_OE  out  1  drive RAM_WDATA onto bus.
- RAM_RDATA  in  WIDTH  bus data from memory; synchronous read, valid the cycle after the read enable.

Behaviour:
- Reset values: state = CPU_OWN; HALT = 0; LD_GNT = 0; LD_ACK = 0; LD_ERR = 0; LD_RDATA = 0; pointer = 0; RAM_WDATA_OE = 0. RST mid-session aborts any access with no ACK.
- States: CPU_OWN, HALT_WAIT, LD_OWN, LD_RDWAIT, RELEASE. Encoding lives in the package.
- CPU_OWN:
  - RAM_ADDR/RAM_EN/RAM_RW pass through combinationally from the CPU_* inputs.
  - LD_REQ = 1 moves to HALT_WAIT next cycle and clears the wait counter.
- HALT_WAIT:
  - CPU passthrough continues; HALT = 0.
  - CPU_BOUNDARY = 1 moves to LD_OWN next cycle; HALT and LD_GNT are registered high.
  - LD_REQ dropping returns to CPU_OWN.
  - Counter reaching TIMEOUT-1 sets LD_ERR and returns to CPU_OWN. LD_REQ must fall and rise again to retry.
- LD_OWN:
  - HALT = 1; CPU_* inputs are ignored; RAM_ADDR = pointer.
  - Write (LD_WR):
    - Same cycle: RAM_EN = 1, RAM_RW = 1, RAM_WDATA_OE = 1.
    - LD_ACK pulses the next cycle.
    - Pointer increments.
  - Read (LD_RD without LD_WR):
    - Same cycle: RAM_EN = 1, RAM_RW = 0; then go to LD_RDWAIT.
    - Pointer increments.
  - LD_WR and LD_RD together: write wins, read dropped.
  - LD_ADDR_LOAD in the same cycle as an access: the access uses LD_ADDR, and the pointer becomes LD_ADDR + 1.
  - Pointer wraps 2^ADDR_WIDTH-1 → 0.
  - LD_REQ = 0 with no access → RELEASE.
- LD_RDWAIT:
  - RAM_EN = 0; capture RAM_RDATA into LD_RDATA; LD_ACK = 1 in the same cycle as the registered update.
  - Strobes this cycle are ignored; the loader must wait for ACK.
  - Return to LD_OWN, or to RELEASE if LD_REQ = 0.
  - LD_REQ dropping during an access: the access completes and ACK is still issued; then RELEASE.
- RELEASE:
  - One turnaround cycle: RAM_EN = 0, RAM_WDATA_OE = 0, HALT = 1, LD_GNT = 0.
  - Then CPU_OWN with HALT = 0 and passthrough restored. LD_REQ high in RELEASE is ignored.
- Throughput:
  - Writes: one per cycle, back-to-back.
  - Reads: one per 2 cycles.
  - Request to grant: 2 cycles minimum (boundary already high).
- RAM_WDATA_OE is never high outside a loader write cycle, so there is no bus contention with CPU drivers.

Decomposition:
- Package ram_arb_pkg holds:
  - the state enum;
  - RW encoding constants RAM_READ = 0 and RAM_WRITE = 1;
  - the default widths.
- One sub-module, arb_addr_pointer: load, increment, wrap counter. Reusable by a future DMA.
- The FSM, mux and timeout counter stay in the top.

Test Plan:
- Reset then idle: CPU_ADDR = 0x0012, CPU_RAM_EN = 1 → RAM_ADDR = 0x0012, RAM_EN = 1, HALT = 0 in the same cycle.
- Grant handshake: LD_REQ = 1 at cycle 0 with CPU_BOUNDARY low until cycle 5 → HALT = 1 and LD_GNT = 1 at cycle 6; no loader RAM_EN before then.
- Burst write: LD_ADDR = 0xFFFE with load, then 3 back-to-back writes 0xAAAA, 0xBBBB, 0xCCCC → ADDR sequence 0xFFFE, 0xFFFF, 0x0000; 3 ACKs; pointer ends at 0x0001.
- Read: pointer = 0x0100, RAM holds 0x1234, LD_RD → LD_RDATA = 0x1234 with LD_ACK 2 cycles after the strobe; pointer = 0x0101.
- Release mid-read: drop LD_REQ in the LD_RD cycle → ACK still issued, one RELEASE cycle with RAM_EN = 0, HALT low one cycle later.
- Timeout and reset: TIMEOUT = 8, CPU_BOUNDARY held 0 → LD_ERR = 1 after 8 cycles in HALT_WAIT, HALT never asserted. RST asserted in LD_OWN → all outputs at reset values next cycle.
